mux_sel_sequencer: RTL
======================

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous reset, active-high).
REQ-002 start  input  1  request to capture din and begin a 4-step select sweep.
REQ-003 din  input  4  parallel data word, sampled on an accepted start.
REQ-004 step  input  1  advance enable; sel moves only on cycles with step=1.
REQ-005 ready  output  1  high in IDLE; start is accepted only when ready=1.
REQ-006 busy  output  1  high in SHIFT.
REQ-007 word  output  4  captured data word, held stable from capture until the next accepted start.
REQ-008 sel  output  2  channel select driven to the downstream 4:1 mux.
REQ-009 qbit  output  1  registered word[sel], the serial bit for the current channel.
REQ-010 valid  output  1  high while sel/qbit present a legal channel (SHIFT only).
REQ-011 last  output  1  high while valid=1 and sel is the final channel of the sweep.
REQ-012 done  output  1  one-cycle pulse after the final channel is stepped past.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL, on the next edge, capture din into word, load sel with the first channel and enter SHIFT.
REQ-015 In SHIFT with step=1 and last=0, sel SHALL advance by one channel per edge.
REQ-016 In SHIFT with step=0, sel, qbit and state SHALL hold.
REQ-017 In SHIFT with step=1 and last=1, the FSM SHALL enter DONE, and valid SHALL drop on that edge.
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-019 start SHALL be ignored in SHIFT and DONE, with no recapture and no sweep restart.
REQ-020 qbit SHALL equal word[sel] in the same cycle sel is presented, with zero added latency relative to sel.
REQ-021 A full sweep with step held at 1 SHALL take 4 cycles in SHIFT plus 1 cycle in DONE: start-accept to done = 5 edges.
REQ-022 sel SHALL be 2 bits wide and SHALL never wrap inside a sweep; the terminal channel always exits to DONE.
REQ-023 A start asserted in the same cycle as done SHALL be ignored; ready returns one cycle later.
REQ-024 ready, busy and done SHALL be mutually exclusive in every cycle.

Reset
REQ-025 rst=1 SHALL force IDLE on the next edge from any state, aborting a sweep in progress.
REQ-026 Reset values SHALL be: ready=1, busy=0, word=0000, sel=00, qbit=0, valid=0, last=0, done=0.
REQ-027 rst SHALL take priority over start and step in the same cycle.

Configuration
REQ-028 Macro MUX_SEQ_MSB_FIRST_EN defined: the first channel SHALL be 11, sel SHALL decrement, and last SHALL be asserted at sel=00.
REQ-029 Macro MUX_SEQ_MSB_FIRST_EN undefined: the first channel SHALL be 00, sel SHALL increment, and last SHALL be asserted at sel=11.
REQ-030 All timing, handshake and reset behaviour SHALL be identical in both builds.

Structure
REQ-031 Package mux_seq_pkg SHALL hold the state enum typedef (IDLE/SHIFT/DONE), NUM_CH=4 and SEL_W=2.
REQ-032 Sub-module mux_seq_bitsel SHALL be the combinational 4:1 selector computing word[sel]; the parent registers its output into qbit.

Verification
REQ-033 Reset: rst=1 for 2 cycles mid-SHIFT -> IDLE, ready=1, word=0000, sel=00, valid=0, done=0.
REQ-034 LSB-first sweep: din=1011, start for 1 cycle, step=1 -> sel 00,01,10,11; qbit 1,1,0,1; last on sel=11; done pulse at edge 5.
REQ-035 Stall: din=0100, step toggles 1,0,0,1,1,1 -> sel holds during step=0, qbit=1 only at sel=10, done exactly once.
REQ-036 Start while busy: start pulsed at sel=01 with din=1111 -> word stays 0100 and the sweep continues unchanged.
REQ-037 MSB-first build: din=1000, start, step=1 -> sel 11,10,01,00; qbit 1,0,0,0; last at sel=00.
REQ-038 Back-to-back: start held high continuously -> sweeps separated by DONE and one IDLE cycle; each sweep captures din at its IDLE cycle.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared state type and channel-order constants for mux_sel_sequencer.
// Define MUX_SEQ_MSB_FIRST_EN to sweep channels 11 -> 00 instead of 00 -> 11.
package mux_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

`ifdef MUX_SEQ_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_CH = 2'b11;
    localparam logic [SEL_W-1:0] LAST_CH  = 2'b00;

    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return ch - SEL_W'(1);
    endfunction
`else
    localparam logic [SEL_W-1:0] FIRST_CH = 2'b00;
    localparam logic [SEL_W-1:0] LAST_CH  = 2'b11;

    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return ch + SEL_W'(1);
    endfunction
`endif

endpackage

// File: rtl/mux_seq_bitsel.sv
// Combinational 4:1 bit selector: o_bit = i_word[i_sel].
module mux_seq_bitsel
    import mux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] i_word,
    input  logic [SEL_W-1:0]  i_sel,
    output logic              o_bit
);

    assign o_bit = i_word[i_sel];

endmodule

// File: rtl/mux_sel_sequencer.sv
// Captures a 4-bit word and sweeps a 2-bit mux select across its channels.
// Channel order follows MUX_SEQ_MSB_FIRST_EN (see mux_seq_pkg).
module mux_sel_sequencer
    import mux_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] din,
    input  logic              step,
    output logic              ready,
    output logic              busy,
    output logic [NUM_CH-1:0] word,
    output logic [SEL_W-1:0]  sel,
    output logic              qbit,
    output logic              valid,
    output logic              last,
    output logic              done
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [NUM_CH-1:0]   r_word;
    logic [NUM_CH-1:0]   w_word_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                r_qbit;
    logic                w_bit;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_sel_nxt   = r_sel;
        ready       = 1'b0;
        busy        = 1'b0;
        valid       = 1'b0;
        last        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_word_nxt  = din;
                    w_sel_nxt   = FIRST_CH;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                valid = 1'b1;
                last  = (r_sel == LAST_CH);
                if (step) begin
                    if (r_sel == LAST_CH) w_state_nxt = DONE;
                    else                  w_sel_nxt   = next_ch(r_sel);
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Select on the next-cycle word/sel so qbit lands in the same cycle as sel.
    mux_seq_bitsel u_bitsel (
        .i_word (w_word_nxt),
        .i_sel  (w_sel_nxt),
        .o_bit  (w_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_sel  <= '0;
            r_qbit <= 1'b0;
        end else begin
            r_word <= w_word_nxt;
            r_sel  <= w_sel_nxt;
            r_qbit <= w_bit;
        end
    end

    assign word = r_word;
    assign sel  = r_sel;
    assign qbit = r_qbit;

endmodule
